// File: rtl/cpu_p_pkg.sv
// Shared definitions for the parametrised accumulator CPU: opcodes, FSM states
// and instruction-field extraction helpers.
package cpu_p_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC_RD = 3'd2,
        ST_EXEC_WR = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

    // Instruction words are widened to this size before field extraction
    localparam int unsigned FIELD_W = 64;

    function automatic logic [2:0] get_opcode(input logic [FIELD_W-1:0] ir,
                                              input int unsigned addr_w);
        logic [FIELD_W-1:0] shifted;
        shifted = ir >> addr_w;
        return shifted[2:0];
    endfunction

    function automatic logic [FIELD_W-1:0] get_operand(input logic [FIELD_W-1:0] ir,
                                                       input int unsigned addr_w);
        logic [FIELD_W-1:0] mask;
        mask = (64'd1 << addr_w) - 64'd1;
        return ir & mask;
    endfunction

endpackage

// File: rtl/cpu_core_p_alu.sv
// Combinational datapath for the read-type instructions: produces the new
// accumulator value and the carry out of an ADD.
module cpu_alu_p
    import cpu_p_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    // Select the operation; non-ALU opcodes leave the accumulator unchanged
    always_comb begin
        result    = acc;
        carry_out = 1'b0;
        case (op)
            OP_ADD:  {carry_out, result} = {1'b0, acc} + {1'b0, rdata};
            OP_AND:  result = acc & rdata;
            OP_XOR:  result = acc ^ rdata;
            OP_LDA:  result = rdata;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/cpu_core_p.sv
// Accumulator CPU core with a req/ack memory port (wait states allowed),
// carry flag and halt/resume control.
module cpu_core_p
    import cpu_p_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              resume,
    output logic              halted,
    output logic              carry,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out
);

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   ir;
    logic [2:0]          opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                xfer;

    assign opcode  = get_opcode(FIELD_W'(ir), ADDR_W);
    assign operand = ADDR_W'(get_operand(FIELD_W'(ir), ADDR_W));
    assign xfer    = mem_req && mem_ack;
    assign pc_out  = pc;
    assign acc_out = acc;

    cpu_alu_p #(.DATA_W(DATA_W)) u_alu (
        .op        (opcode),
        .acc       (acc),
        .rdata     (mem_rdata),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // Memory port drive: address/data come straight from held registers, so
    // they stay stable for as long as the request waits; reset gates it off
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                ST_EXEC_RD: begin
                    mem_req  = 1'b1;
                    mem_addr = operand;
                end
                ST_EXEC_WR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = operand;
                    mem_wdata = acc;
                end
                default: mem_req = 1'b0;
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

    // Instruction sequencer and architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= '0;
            acc    <= '0;
            ir     <= '0;
            carry  <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (xfer) begin
                        ir    <= mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_HLT: begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end
                        OP_SKZ: begin
                            if (acc == '0) pc <= pc + ADDR_W'(1);
                            state <= ST_FETCH;
                        end
                        OP_JMP: begin
                            pc    <= operand;
                            state <= ST_FETCH;
                        end
                        OP_STO: state <= ST_EXEC_WR;
                        OP_ADD, OP_AND, OP_XOR, OP_LDA: state <= ST_EXEC_RD;
                        default: state <= ST_FETCH;
                    endcase
                end
                ST_EXEC_RD: begin
                    if (xfer) begin
                        acc <= alu_result;
                        if (opcode == OP_ADD) carry <= alu_carry;
                        state <= ST_FETCH;
                    end
                end
                ST_EXEC_WR: begin
                    if (xfer) state <= ST_FETCH;
                end
                ST_HALTED: begin
                    if (resume) begin
                        state  <= ST_FETCH;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_FETCH;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_p.sv
// Self-checking bench for cpu_core_p: instruction-level reference model,
// memory responder with configurable wait states, per-cycle bus checker.
module tb_cpu_core_p;

    localparam int DW  = 8;
    localparam int AW  = 5;
    localparam int MSZ = 32;

    logic          clk;
    logic          rst;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          resume;
    logic          halted;
    logic          carry;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] acc_out;

    cpu_core_p #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .resume    (resume),
        .halted    (halted),
        .carry     (carry),
        .pc_out    (pc_out),
        .acc_out   (acc_out)
    );

    typedef struct {
        int addr;
        int we;
        int wdata;
    } xfer_t;

    xfer_t       exp_q[$];
    int          seen_q[$];
    logic [7:0]  mem [MSZ];
    logic [7:0]  mm  [MSZ];
    int          n_chk = 0;
    int          n_fail = 0;
    int          wait_n = 0;
    bit          rand_wait = 1'b0;
    bit          chk_en = 1'b0;
    bit          busy = 1'b0;
    int          wcnt = 0;
    int          cur_wait = 0;
    bit          prev_pend = 1'b0;
    logic [31:0] p_addr, p_we, p_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: decides ack after the core's outputs have settled
    always begin
        @(negedge clk);
        #1;
        if (mem_req) begin
            if (!busy) begin
                busy     = 1'b1;
                wcnt     = 0;
                cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_n;
            end
            if (wcnt >= cur_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                busy = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wcnt++;
            end
        end else begin
            busy      = 1'b0;
            mem_ack   = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 8'($urandom);
        end
    end

    // Bus checker: completed transfers against the model, held signals during waits
    always begin
        @(negedge clk);
        #2;
        if (!chk_en) begin
            prev_pend = 1'b0;
        end else begin
            if (mem_req && prev_pend) begin
                chk("hold_addr", mem_addr, p_addr);
                chk("hold_we", mem_we, p_we);
                chk("hold_wdata", mem_wdata, p_wdata);
            end
            if (mem_req && mem_ack) begin
                seen_q.push_back(int'(mem_addr));
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_xfer: got transfer at 0x%0h, expected none", mem_addr);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    chk("xfer_addr", mem_addr, e.addr);
                    chk("xfer_we", mem_we, e.we);
                    if (e.we != 0) chk("xfer_wdata", mem_wdata, e.wdata);
                end
            end
            prev_pend = mem_req && !mem_ack;
            p_addr    = 32'(mem_addr);
            p_we      = 32'(mem_we);
            p_wdata   = 32'(mem_wdata);
        end
    end

    // Instruction-level model: runs the program in mm, queues expected transfers
    task automatic model(input int wn, input int max_instr, output int mcyc, output bit mhalt,
                         output int mpc, output int macc, output int mcar);
        int pc, acc, car, ir, op, opd, v, sum;
        pc = 0; acc = 0; car = 0; mcyc = 0; mhalt = 1'b0;
        exp_q.delete();
        for (int i = 0; i < max_instr && !mhalt; i++) begin
            ir = int'(mm[pc]);
            exp_q.push_back('{pc, 0, 0});
            pc   = (pc + 1) % MSZ;
            op   = ir / 32;
            opd  = ir % 32;
            mcyc += 2 + wn;
            case (op)
                0: mhalt = 1'b1;
                1: if (acc == 0) pc = (pc + 1) % MSZ;
                7: pc = opd;
                6: begin
                    exp_q.push_back('{opd, 1, acc});
                    mm[opd] = 8'(acc);
                    mcyc += 1 + wn;
                end
                default: begin
                    exp_q.push_back('{opd, 0, 0});
                    v = int'(mm[opd]);
                    mcyc += 1 + wn;
                    case (op)
                        2: begin sum = acc + v; car = sum / 256; acc = sum % 256; end
                        3: acc = acc & v;
                        4: acc = acc ^ v;
                        default: acc = v;
                    endcase
                end
            endcase
        end
        mpc = pc; macc = acc; mcar = car;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        resume = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    task automatic run_prog(input string tag, input int wn, input bit rmode, input bit rsm,
                            input int max_instr, output int cyc);
        int mcyc, mpc, macc, mcar, diffs;
        bit mhalt, done;
        mm = mem;
        model(wn, max_instr, mcyc, mhalt, mpc, macc, mcar);
        wait_n    = wn;
        rand_wait = rmode;
        seen_q.delete();
        do_reset();
        chk_en = 1'b1;
        cyc    = 0;
        done   = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #3;
            cyc++;
            if (halted || (!mhalt && exp_q.size() == 0)) begin
                done = 1'b1;
                break;
            end
            resume = rsm ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        resume = 1'b0;
        chk_en = 1'b0;
        chk({tag, "_finished"}, done, 1);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_halted"}, halted, mhalt);
        if (mhalt) begin
            chk({tag, "_pc"}, pc_out, mpc);
            chk({tag, "_acc"}, acc_out, macc);
            chk({tag, "_carry"}, carry, mcar);
            if (!rmode) chk({tag, "_cycles"}, cyc, mcyc);
        end
        diffs = 0;
        foreach (mem[i]) if (mem[i] !== mm[i]) diffs++;
        chk({tag, "_mem_diffs"}, diffs, 0);
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0]  = 8'hAA;
        mem[1]  = 8'h4B;
        mem[2]  = 8'hCC;
        mem[3]  = 8'h00;
        mem[10] = 8'h07;
        mem[11] = 8'hFC;
    endtask

    initial begin
        int cyc;
        bit found;
        rst = 1'b1; resume = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        clear_mem();

        repeat (2) @(negedge clk);
        #3;
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_carry", carry, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);

        load_prog1();
        run_prog("prog1", 0, 1'b0, 1'b0, 50, cyc);
        chk("prog1_lit_cycles", cyc, 11);
        chk("prog1_lit_mem12", mem[12], 8'h03);
        chk("prog1_lit_acc", acc_out, 8'h03);
        chk("prog1_lit_carry", carry, 1);
        chk("prog1_lit_pc", pc_out, 4);

        // Halted at pc=4 with mem[4]=0: one resume pulse runs exactly one HLT
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        #3;
        chk("resume_halted_drop", halted, 0);
        chk("resume_req", mem_req, 1);
        chk("resume_addr", mem_addr, 4);
        chk("resume_we", mem_we, 0);
        @(negedge clk);
        #3;
        chk("resume_decode", halted, 0);
        @(negedge clk);
        #3;
        chk("resume_rehalt", halted, 1);
        chk("resume_pc", pc_out, 5);

        load_prog1();
        run_prog("resume_noise", 0, 1'b0, 1'b1, 50, cyc);
        chk("resume_noise_cycles", cyc, 11);

        clear_mem();
        mem[0] = 8'h20;
        mem[1] = 8'hE5;
        mem[2] = 8'h00;
        run_prog("skz", 0, 1'b0, 1'b0, 50, cyc);
        chk("skz_lit_pc", pc_out, 3);
        chk("skz_nfetch", seen_q.size(), 2);
        chk("skz_fetch0", seen_q[0], 0);
        chk("skz_fetch1", seen_q[1], 2);

        load_prog1();
        run_prog("wait3", 3, 1'b0, 1'b0, 50, cyc);
        chk("wait3_lit_cycles", cyc, 32);
        chk("wait3_lit_mem12", mem[12], 8'h03);

        clear_mem();
        mem[0]  = 8'hFF;
        mem[31] = 8'h20;
        mem[1]  = 8'h00;
        run_prog("wrap", 0, 1'b0, 1'b0, 50, cyc);
        chk("wrap_lit_pc", pc_out, 2);
        chk("wrap_nfetch", seen_q.size(), 3);
        chk("wrap_fetch0", seen_q[0], 0);
        chk("wrap_fetch1", seen_q[1], 31);
        chk("wrap_fetch2", seen_q[2], 1);

        // Reset arrives while the STO write is still waiting for its ack
        load_prog1();
        mem[12]   = 8'h55;
        wait_n    = 3;
        rand_wait = 1'b0;
        chk_en    = 1'b0;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #3;
            if (mem_req && mem_we) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstmid_reach_wr", found, 1);
        chk("rstmid_pre_acc", acc_out, 8'h03);
        chk("rstmid_pre_carry", carry, 1);
        @(negedge clk);
        rst = 1'b1;
        #3;
        chk("rstmid_req_gated", mem_req, 0);
        chk("rstmid_we_gated", mem_we, 0);
        chk("rstmid_wdata_gated", mem_wdata, 0);
        @(negedge clk);
        #3;
        chk("rstmid_acc", acc_out, 0);
        chk("rstmid_carry", carry, 0);
        chk("rstmid_pc", pc_out, 0);
        chk("rstmid_no_write", mem[12], 8'h55);
        rst = 1'b0;
        #1;
        chk("rstmid_first_req", mem_req, 1);
        chk("rstmid_first_we", mem_we, 0);
        chk("rstmid_first_addr", mem_addr, 0);

        for (int r = 0; r < 10; r++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            run_prog("rand", 0, 1'b1, 1'b1, 40, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
